// File: rtl/brute_force_matcher_secondary_buffer.sv
// Secondary-keypoint buffer: loads one descriptor from an FWFT FIFO and replays it word-aligned with streamed primaries.
// Optional load-stall counter enabled by defining BFM_SEC_BUF_STALL_CNT_EN.
module brute_force_matcher_secondary_buffer #(
    parameter int C_ELEM_WIDTH          = 8,
    parameter int C_SIMD                = 16,
    parameter int C_NUM_ELEMENTS_PER_KP = 4,
    parameter int C_KP_ID_WIDTH         = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            buffer_load_init,
    input  logic                            buffer_load_enable,
    output logic                            buffer_load_valid,
    output logic                            fifo_rd_en,
    input  logic                            fifo_empty,
    input  logic [C_SIMD*C_ELEM_WIDTH-1:0]  fifo_dout,
    input  logic                            descriptor_valid,
    output logic                            keypoint_advance,
    input  logic [C_KP_ID_WIDTH-1:0]        num_prim_kp,
    input  logic                            prim_valid,
    output logic                            prim_ready,
    input  logic [C_SIMD*C_ELEM_WIDTH-1:0]  prim_data,
    output logic                            out_valid,
    output logic [C_SIMD*C_ELEM_WIDTH-1:0]  out_prim_data,
    output logic [C_SIMD*C_ELEM_WIDTH-1:0]  out_sec_data,
    output logic                            out_last,
    output logic [C_KP_ID_WIDTH-1:0]        out_prim_id,
    output logic [C_KP_ID_WIDTH-1:0]        out_sec_id,
    output logic [31:0]                     stall_count
);

    localparam int DATA_W = C_SIMD * C_ELEM_WIDTH;
    localparam int PTR_W  = $clog2(C_NUM_ELEMENTS_PER_KP + 1);
    localparam int IDX_W  = (C_NUM_ELEMENTS_PER_KP > 1) ? $clog2(C_NUM_ELEMENTS_PER_KP) : 1;
    localparam logic [PTR_W-1:0]         WORDS    = PTR_W'(C_NUM_ELEMENTS_PER_KP);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(C_NUM_ELEMENTS_PER_KP - 1);
    localparam logic [C_KP_ID_WIDTH-1:0] ONE_ID   = C_KP_ID_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        ADVANCE = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [PTR_W-1:0]         wr_ptr;
    logic [DATA_W-1:0]        word_mem [C_NUM_ELEMENTS_PER_KP];
    logic [IDX_W-1:0]         rd_idx;
    logic [C_KP_ID_WIDTH-1:0] prim_target;
    logic [C_KP_ID_WIDTH-1:0] prim_id;
    logic [C_KP_ID_WIDTH-1:0] sec_id;
    logic                     adv_done;
    logic                     load_room;
    logic                     accept;
    logic                     wrap;
    logic                     pass_end;

    logic                     vld_p1;
    logic                     last_p1;
    logic [DATA_W-1:0]        prim_p1;
    logic [DATA_W-1:0]        sec_p1;
    logic [C_KP_ID_WIDTH-1:0] prim_id_p1;

    // Pops are suppressed during reset so an aborted load never loses a FIFO word.
    assign load_room         = (wr_ptr < WORDS);
    assign fifo_rd_en        = !rst && buffer_load_enable && !fifo_empty && load_room;
    assign buffer_load_valid = fifo_rd_en;

    assign prim_ready = (state == STREAM) && descriptor_valid && !buffer_load_init;
    assign accept     = prim_valid && prim_ready;
    assign wrap       = (rd_idx == LAST_IDX);
    assign pass_end   = accept && wrap && (prim_id == prim_target - ONE_ID);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (descriptor_valid && !adv_done && !buffer_load_init)
                    state_nxt = (prim_target == '0) ? ADVANCE : STREAM;
            end
            STREAM: begin
                if (buffer_load_init)
                    state_nxt = IDLE;
                else if (pass_end)
                    state_nxt = ADVANCE;
            end
            ADVANCE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_idx           <= '0;
            prim_target      <= '0;
            prim_id          <= '0;
            sec_id           <= '0;
            adv_done         <= 1'b0;
            keypoint_advance <= 1'b0;
        end else begin
            state            <= state_nxt;
            keypoint_advance <= (state == ADVANCE);
            if (state == ADVANCE)
                sec_id <= sec_id + ONE_ID;
            if (buffer_load_init) begin
                wr_ptr      <= '0;
                prim_target <= num_prim_kp;
                rd_idx      <= '0;
                prim_id     <= '0;
                adv_done    <= 1'b0;
            end else begin
                if (fifo_rd_en)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (state == ADVANCE)
                    adv_done <= 1'b1;
                if (accept) begin
                    rd_idx <= wrap ? '0 : rd_idx + IDX_W'(1);
                    if (wrap)
                        prim_id <= prim_id + ONE_ID;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_ELEMENTS_PER_KP; i++)
                word_mem[i] <= '0;
        end else if (fifo_rd_en) begin
            word_mem[wr_ptr[IDX_W-1:0]] <= fifo_dout;
        end
    end

    // ---- stage p1: paired primary/secondary word registered toward the distance pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            prim_p1    <= '0;
            sec_p1     <= '0;
            prim_id_p1 <= '0;
        end else begin
            vld_p1  <= accept;
            last_p1 <= accept && wrap;
            if (accept) begin
                prim_p1    <= prim_data;
                sec_p1     <= word_mem[rd_idx];
                prim_id_p1 <= prim_id;
            end
        end
    end

    assign out_valid     = vld_p1;
    assign out_last      = last_p1;
    assign out_prim_data = prim_p1;
    assign out_sec_data  = sec_p1;
    assign out_prim_id   = prim_id_p1;
    assign out_sec_id    = sec_id;

`ifdef BFM_SEC_BUF_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (buffer_load_enable && fifo_empty && load_room && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: doc/brute_force_matcher_secondary_buffer.md
Name: brute_force_matcher_secondary_buffer

Overview:
Datapath stage directly downstream of the secondary-buffer controller. It pops one secondary keypoint descriptor from the FWFT sync FIFO into a local word array while the controller is in its load phase. It then replays that descriptor word by word, aligned with the streamed primary descriptors, into the distance-compute pipeline. It generates keypoint_advance back to the controller once every primary keypoint has been compared against the held secondary keypoint.

Parameters:
C_ELEM_WIDTH, 8, bits per descriptor element
C_SIMD, 16, elements per FIFO/datapath word
C_NUM_ELEMENTS_PER_KP, 4, words per descriptor (descriptor elements / C_SIMD)
C_KP_ID_WIDTH, 16, width of keypoint counters and num_prim_kp

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
buffer_load_init  in  1  controller init-phase strobe; clears write pointer
buffer_load_enable  in  1  controller load phase active
buffer_load_valid  out  1  one word accepted from FIFO this cycle
fifo_rd_en  out  1  FWFT FIFO pop
fifo_empty  in  1  FIFO empty
fifo_dout  in  C_SIMD*C_ELEM_WIDTH  FIFO head word
descriptor_valid  in  1  controller holds a complete secondary keypoint
keypoint_advance  out  1  single-cycle pulse: done with current secondary keypoint
num_prim_kp  in  C_KP_ID_WIDTH  primary keypoints per pass; sampled on buffer_load_init
prim_valid  in  1  primary word valid
prim_ready  out  1  primary word accepted when prim_valid && prim_ready
prim_data  in  C_SIMD*C_ELEM_WIDTH  primary descriptor word
out_valid  out  1  paired output valid
out_prim_data  out  C_SIMD*C_ELEM_WIDTH  registered primary word
out_sec_data  out  C_SIMD*C_ELEM_WIDTH  matching secondary word
out_last  out  1  last word of the current primary keypoint
out_prim_id  out  C_KP_ID_WIDTH  primary keypoint index
out_sec_id  out  C_KP_ID_WIDTH  secondary keypoint index
stall_count  out  32  load-stall cycle counter (optional feature)

Behaviour:
- Reset clears all state. All outputs are 0 after reset; out_sec_id is 0.
- Load path:
  - fifo_rd_en = buffer_load_enable && !fifo_empty && (wr_ptr < C_NUM_ELEMENTS_PER_KP).
  - buffer_load_valid = fifo_rd_en; this is combinational, with zero latency.
  - On each pop, word[wr_ptr] <= fifo_dout and wr_ptr increments.
  - buffer_load_init sets wr_ptr to 0, loads num_prim_kp into prim_target, and clears rd_idx, prim_id and adv_done.
  - Once wr_ptr reaches C_NUM_ELEMENTS_PER_KP, no further pops occur even if buffer_load_enable stays high.
- Replay FSM states: IDLE, STREAM, ADVANCE.
  - IDLE -> STREAM when descriptor_valid && !adv_done && prim_target != 0.
  - IDLE -> ADVANCE when descriptor_valid && !adv_done && prim_target == 0.
  - STREAM:
    - prim_ready = 1.
    - On each accepted primary word, out_sec_data <= word[rd_idx] and out_prim_data <= prim_data.
    - Output latency is 1 cycle: out_valid is high the cycle after acceptance.
    - rd_idx increments and wraps at C_NUM_ELEMENTS_PER_KP-1, at which point out_last = 1 and prim_id increments.
    - When a wrap coincides with prim_id == prim_target-1, the FSM goes to ADVANCE.
  - ADVANCE: keypoint_advance = 1 for exactly one cycle, adv_done <= 1, out_sec_id increments, FSM goes to IDLE.
  - adv_done prevents a second pulse while descriptor_valid stays high; it is cleared only by buffer_load_init.
  - prim_ready = 0 in IDLE and ADVANCE.
  - Primary words offered while descriptor_valid = 0 are never accepted.
- out_prim_id and out_sec_id are the values associated with the accepted word.
- out_sec_id wraps modulo 2^C_KP_ID_WIDTH.
- A buffer_load_init arriving in STREAM (protocol violation) forces IDLE and discards the partial pass; no keypoint_advance is emitted.
- Reset during load or stream aborts immediately; the FIFO is not popped in the reset cycle.

Optional Feature:
- Macro BFM_SEC_BUF_STALL_CNT_EN.
- Defined: stall_count increments (saturating at 0xFFFFFFFF) every cycle with buffer_load_enable && fifo_empty && wr_ptr < C_NUM_ELEMENTS_PER_KP. It is cleared only by rst.
- Undefined: stall_count is tied to 0 and no counter logic is generated.

Test Plan:
- FIFO holds 4 words W0..W3, buffer_load_enable high 4 cycles -> fifo_rd_en/buffer_load_valid high 4 consecutive cycles, array = W0..W3; 5th enabled cycle -> no pop.
- num_prim_kp=2, descriptor_valid=1, primary words P0..P7 back-to-back -> out_valid on 8 consecutive cycles with sec words W0,W1,W2,W3,W0,W1,W2,W3; out_last on 4th and 8th; out_prim_id 0,0,0,0,1,1,1,1; keypoint_advance pulses once, 2 cycles after P7 accepted.
- num_prim_kp=0, descriptor_valid=1 -> keypoint_advance one-cycle pulse, no prim_ready, out_sec_id increments by 1.
- descriptor_valid held high 20 cycles after advance -> no second keypoint_advance until the next buffer_load_init.
- fifo_empty toggling during load (2 empty cycles) -> pops only on non-empty cycles; stall_count = 2 with BFM_SEC_BUF_STALL_CNT_EN, 0 without.
- rst asserted mid-STREAM after 3 words -> next cycle all outputs 0, prim_ready=0, wr_ptr=0, out_sec_id=0.
